// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry for the L1 data cache: controller states, latched
// request record and the byte-merge helper used on store hits.
package l1_dcache_pkg;

  localparam int LINE_BITS  = 256;
  localparam int WORD_BITS  = 32;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic [3:0]  mbe;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Replace the enabled bytes of one 32-bit word inside a cacheline.
  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0]  line,
    input logic [WORD_SEL_W-1:0] sel,
    input logic [WORD_BITS-1:0]  wdata,
    input logic [3:0]            mbe
  );
    logic [LINE_BITS-1:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (mbe[b]) res[int'(sel) * WORD_BITS + b * 8 +: 8] = wdata[b * 8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// Load/store-queue and physical-memory buses of the L1 data cache; the cache
// connects through the slave modport, requester and memory through master.
interface l1_dcache_if;
  import l1_dcache_pkg::*;

  // Handshakes: data_read/data_write are held by the requester until the
  // one-cycle data_resp pulse; pmem_read/pmem_write are held by the cache,
  // with address/data stable, until the one-cycle pmem_resp pulse.
  logic                 data_read;
  logic                 data_write;
  logic [3:0]           data_mbe;
  logic [31:0]          data_addr;
  logic [31:0]          data_wdata;
  logic                 data_resp;
  logic [31:0]          data_rdata;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [31:0]          pmem_address;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;

  modport slave (
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    input  pmem_rdata, pmem_resp,
    output data_resp, data_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    output pmem_rdata, pmem_resp,
    input  data_resp, data_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped storage: valid/dirty bits (reset), tag and data lines (no reset),
// one combinational read port and one synchronous write port.
module dcache_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back / write-allocate L1 data cache controller with a
// four-state IDLE/COMPARE/WRITEBACK/ALLOCATE FSM around dcache_array.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic   clk,
  input  logic   rst,
  l1_dcache_if.slave bus,
  output state_t dbg_state
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = index_bits(NUM_SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  state_t state_q, state_d;
  req_t   req_q;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  addr_lo_unused;

  assign req_idx        = req_q.addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag        = req_q.addr[31:OFF_W+IDX_W];
  assign req_word       = req_q.addr[OFF_W-1:2];
  assign addr_lo_unused = ^req_q.addr[1:0];

  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 arr_we, arr_wr_valid, arr_wr_dirty;
  logic [LINE_BITS-1:0] arr_wr_line;
  logic                 hit;

  dcache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (arr_we),
    .wr_index (req_idx),
    .wr_valid (arr_wr_valid),
    .wr_dirty (arr_wr_dirty),
    .wr_tag   (req_tag),
    .wr_line  (arr_wr_line)
  );

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign dbg_state = state_q;

  // The request is captured only on acceptance in IDLE; a simultaneous
  // read+write is recorded as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && (bus.data_read || bus.data_write)) begin
        req_q <= '{write: bus.data_write, mbe: bus.data_mbe,
                   addr: bus.data_addr, wdata: bus.data_wdata};
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    arr_we           = 1'b0;
    arr_wr_valid     = 1'b0;
    arr_wr_dirty     = 1'b0;
    arr_wr_line      = rd_line;
    bus.data_resp    = 1'b0;
    bus.data_rdata   = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.data_read || bus.data_write) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit) begin
          bus.data_resp = 1'b1;
          state_d       = S_IDLE;
          if (!req_q.write) begin
            bus.data_rdata = rd_line[int'(req_word) * WORD_BITS +: WORD_BITS];
          end else if (req_q.mbe != 4'b0000) begin
            // An all-zero byte mask leaves both the line and its dirty bit alone.
            arr_we       = 1'b1;
            arr_wr_valid = 1'b1;
            arr_wr_dirty = 1'b1;
            arr_wr_line  = merge_word(rd_line, req_word, req_q.wdata, req_q.mbe);
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {rd_tag, req_idx, {OFF_W{1'b0}}};
        bus.pmem_wdata   = rd_line;
        if (bus.pmem_resp) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (bus.pmem_resp) begin
          arr_we       = 1'b1;
          arr_wr_valid = 1'b1;
          arr_wr_dirty = 1'b0;
          arr_wr_line  = bus.pmem_rdata;
          state_d      = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Randomised bench for l1_dcache: a set-array cache model with a backing
// memory predicts read data and the exact sequence of memory transactions.
module tb_l1_dcache;
  import l1_dcache_pkg::*;

  localparam int NSETS = 16;
  localparam int EW    = 1 + 32 + 256;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  l1_dcache_if bus();

  l1_dcache #(.NUM_SETS(NSETS), .LINE_BYTES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];   // {is_write, line address, writeback data}
  int force_delay = -1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [255:0] ref_mem  [logic [31:0]];
  logic [255:0] phys_mem [logic [31:0]];
  bit           m_valid [NSETS];
  bit           m_dirty [NSETS];
  logic [22:0]  m_tag   [NSETS];
  logic [255:0] m_line  [NSETS];

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la * 32'h9E37_79B1 + 32'(w) * 32'h0101_0101;
    return l;
  endfunction

  function automatic logic [255:0] ref_get(input logic [31:0] la);
    if (ref_mem.exists(la)) return ref_mem[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] phys_get(input logic [31:0] la);
    if (phys_mem.exists(la)) return phys_mem[la];
    return init_line(la);
  endfunction

  task automatic preload(input logic [31:0] la, input logic [255:0] line);
    ref_mem[la]  = line;
    phys_mem[la] = line;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSETS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] mbe, output bit hit, output logic [31:0] rdata);
    int          idx;
    int          w;
    logic [22:0] tag;
    logic [31:0] la;
    logic [31:0] va;
    idx = int'(addr[8:5]);
    w   = int'(addr[4:2]);
    tag = addr[31:9];
    la  = {addr[31:5], 5'b0};
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], 4'(idx), 5'b0};
        ref_mem[va] = m_line[idx];
        exp_q.push_back({1'b1, va, m_line[idx]});
      end
      exp_q.push_back({1'b0, la, 256'h0});
      m_line[idx]  = ref_get(la);
      m_tag[idx]   = tag;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (mbe[b]) m_line[idx][w*32 + b*8 +: 8] = wdata[b*8 +: 8];
      if (mbe != 4'b0000) m_dirty[idx] = 1;
    end
    rdata = m_line[idx][w*32 +: 32];
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && (bus.pmem_read || bus.pmem_write)) begin
        logic          k;
        logic [31:0]   a;
        logic [255:0]  d;
        logic [EW-1:0] e;
        int            dly;
        bit            aborted;
        check("pmem_exclusive", {bus.pmem_read, bus.pmem_write}, (bus.pmem_write ? 2'b01 : 2'b10));
        k = bus.pmem_write;
        a = bus.pmem_address;
        d = bus.pmem_wdata;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 32'hFFFF_FFFF, 256'h0};
        check("pmem_kind", k, e[EW-1]);
        check("pmem_addr", a, e[287:256]);
        if (k) check("pmem_wdata", d, e[255:0]);
        dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        aborted = 0;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1;
            break;
          end
          check("pmem_hold", {bus.pmem_write, bus.pmem_read, bus.pmem_address}, {k, ~k, a});
          check("no_resp_during_mem", bus.data_resp, 0);
        end
        if (!aborted) begin
          if (k) phys_mem[a] = d;
          else   bus.pmem_rdata = phys_get(a);
          bus.pmem_resp = 1'b1;
          @(negedge clk);
          bus.pmem_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge with the DUT in IDLE; returns on a negedge in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mbe, output logic [31:0] got);
    bit          exp_hit;
    logic [31:0] exp_rd;
    int          cyc;
    model_access(wr, addr, wdata, mbe, exp_hit, exp_rd);
    bus.data_read  = rd;
    bus.data_write = wr;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    bus.data_mbe   = mbe;
    @(posedge clk);
    cyc = 0;
    got = '0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.data_resp) begin
        bus.data_addr  = $urandom;
        bus.data_wdata = $urandom;
        bus.data_mbe   = 4'($urandom_range(0, 15));
      end
    end while (!bus.data_resp && cyc < 300);
    check("resp_seen", bus.data_resp, 1);
    if (bus.data_resp) begin
      got = bus.data_rdata;
      if (!wr) check("rdata", got, exp_rd);
      if (exp_hit) check("hit_latency", cyc, 1);
      check("pmem_idle_on_resp", {bus.pmem_read, bus.pmem_write}, 0);
    end
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {bus.data_resp, dbg_state}, {1'b0, S_IDLE});
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] line;
    logic [31:0]  got;
    bit           dummy_hit;
    logic [31:0]  dummy_rd;
    int           n;
    logic [31:0]  a;
    int           op;

    rst            = 1'b0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.data_mbe   = 4'h0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data_resp", bus.data_resp, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    check("rst_data_rdata", bus.data_rdata, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // Cold read miss, then a masked store hit and read-back.
    line = init_line(32'h0000_1000);
    line[63:32] = 32'hDEAD_BEEF;
    line[95:64] = 32'hAABB_CCDD;
    preload(32'h0000_1000, line);
    access(1, 0, 32'h0000_1004, 32'h0, 4'h0, got);
    check("cold_read_word", got, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_1008, 32'h1122_3344, 4'b0101, got);
    access(1, 0, 32'h0000_1008, 32'h0, 4'h0, got);
    check("merged_word", got, 32'hAA22_CC44);

    // Conflict miss on a dirty line: writeback of 0x1000, then fill of 0x3000.
    access(1, 0, 32'h0000_3008, 32'h0, 4'h0, got);

    // Slow memory: responder verifies the request is held for 10 cycles.
    force_delay = 10;
    access(1, 0, 32'h0000_2040, 32'h0, 4'h0, got);
    force_delay = -1;

    // Reset while ALLOCATE is outstanding.
    force_delay = 20;
    model_access(0, 32'h0000_5080, 32'h0, 4'h0, dummy_hit, dummy_rd);
    bus.data_read = 1'b1;
    bus.data_addr = 32'h0000_5080;
    @(posedge clk);
    n = 0;
    while (!bus.pmem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("alloc_seen", bus.pmem_read, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_drops_pmem_read", bus.pmem_read, 0);
    check("rst_mid_state", dbg_state, S_IDLE);
    check("rst_mid_resp", bus.data_resp, 0);
    bus.data_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    force_delay = -1;
    rst = 1'b1;
    @(negedge clk);
    access(1, 0, 32'h0000_5080, 32'h0, 4'h0, got);

    // Simultaneous read and write is a write.
    access(1, 1, 32'h0000_60C0, 32'h0000_0055, 4'b1111, got);
    access(1, 0, 32'h0000_60C0, 32'h0, 4'h0, got);
    check("rw_as_write", got, 32'h0000_0055);

    // Random traffic over a small tag pool to force hits, conflicts and evictions.
    for (int i = 0; i < 300; i++) begin
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
           32'($urandom_range(0, 31));
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
